// File: rtl/usb_burst_reader.sv
// Drains fixed-length bursts of 10-bit offset-binary samples from a read-ahead FIFO
// and presents them as 16-bit two's-complement words to a USB endpoint.
module usb_burst_reader #(
  parameter int BURST_WORDS = 8192
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  fifoData,
  input  logic        fifoEmpty,
  input  logic        fifoHalfFull,
  output logic        fifoAck,
  input  logic        usbReady,
  input  logic        testMode,
  output logic [15:0] usbData,
  output logic        usbWrite,
  output logic        usbEndBurst,
  output logic        underrun,
  output logic        busy
);

  localparam int CW = $clog2(BURST_WORDS);
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST_WORDS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   word_count_reg, word_count_next;
  logic [9:0]      test_count_reg, test_count_next;
  logic [15:0]     usb_data_reg, usb_data_next;
  logic            usb_write_reg, usb_write_next;
  logic            end_burst_reg, end_burst_next;
  logic            underrun_reg, underrun_next;
  logic            busy_reg, busy_next;
  logic [9:0]      sample;

  // Test mode swaps the payload only; the FIFO is still drained word for word.
  assign sample = testMode ? test_count_reg : fifoData;

  always_comb begin
    state_next      = state_reg;
    word_count_next = word_count_reg;
    test_count_next = test_count_reg;
    usb_data_next   = usb_data_reg;
    usb_write_next  = 1'b0;
    end_burst_next  = 1'b0;
    underrun_next   = underrun_reg;
    fifoAck         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (fifoHalfFull && usbReady) begin
          state_next      = STREAM;
          word_count_next = '0;
        end
      end
      STREAM: begin
        fifoAck = usbReady & ~fifoEmpty & ~reset;
        if (usbReady && fifoEmpty) underrun_next = 1'b1;
        if (fifoAck) begin
          // Flipping the MSB turns offset binary into two's complement; then sign-extend.
          usb_data_next   = {{6{~sample[9]}}, ~sample[9], sample[8:0]};
          usb_write_next  = 1'b1;
          test_count_next = test_count_reg + 10'd1;
          if (word_count_reg == LAST_WORD) begin
            end_burst_next  = 1'b1;
            state_next      = IDLE;
            word_count_next = '0;
          end else begin
            word_count_next = word_count_reg + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next == STREAM) | usb_write_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      word_count_reg <= '0;
      test_count_reg <= '0;
      usb_data_reg   <= '0;
      usb_write_reg  <= 1'b0;
      end_burst_reg  <= 1'b0;
      underrun_reg   <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      word_count_reg <= word_count_next;
      test_count_reg <= test_count_next;
      usb_data_reg   <= usb_data_next;
      usb_write_reg  <= usb_write_next;
      end_burst_reg  <= end_burst_next;
      underrun_reg   <= underrun_next;
      busy_reg       <= busy_next;
    end
  end

  assign usbData     = usb_data_reg;
  assign usbWrite    = usb_write_reg;
  assign usbEndBurst = end_burst_reg;
  assign underrun    = underrun_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_usb_burst_reader.sv
// Self-checking bench for usb_burst_reader: a read-ahead FIFO model feeds the DUT and a
// queue scoreboard predicts every USB word from the offset-binary arithmetic.
module tb_usb_burst_reader;

  localparam int BURST = 8192;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  fifoData;
  logic        fifoEmpty = 1'b0;
  logic        fifoHalfFull = 1'b0;
  logic        fifoAck;
  logic        usbReady = 1'b0;
  logic        testMode = 1'b0;
  logic [15:0] usbData;
  logic        usbWrite;
  logic        usbEndBurst;
  logic        underrun;
  logic        busy;

  usb_burst_reader #(.BURST_WORDS(BURST)) dut (
    .clock(clk), .reset(reset), .fifoData(fifoData), .fifoEmpty(fifoEmpty),
    .fifoHalfFull(fifoHalfFull), .fifoAck(fifoAck), .usbReady(usbReady),
    .testMode(testMode), .usbData(usbData), .usbWrite(usbWrite),
    .usbEndBurst(usbEndBurst), .underrun(underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: endless stream of samples, advanced just after the edge that consumed one.
  logic [9:0]  mem [0:65535];
  logic [15:0] rd_ptr = '0;
  bit          pop_pending = 0;
  assign fifoData = mem[rd_ptr];

  always @(posedge clk) begin
    #1;
    if (pop_pending) begin
      rd_ptr++;
      pop_pending = 0;
    end
  end

  // Reference model: a sample s in offset binary is worth s - 512.
  function automatic logic [15:0] conv(input int s);
    return 16'(s - 512);
  endfunction

  logic [15:0] exp_q[$];
  logic [15:0] wr_log[$];
  bit          log_en = 0;
  bit          expect_zero = 0;
  int          tc_model = 0;
  int          writes_in_burst = 0;
  int          total_writes = 0;
  int          total_acks = 0;

  always @(negedge clk) begin
    if (usbWrite === 1'b1) begin
      writes_in_burst++;
      total_writes++;
      check("busy_with_write", busy, 1);
      if (exp_q.size() == 0) check("write_without_ack", 1, 0);
      else check("usb_data", usbData, exp_q.pop_front());
      if (log_en) wr_log.push_back(usbData);
    end
    check("end_burst", usbEndBurst, (usbWrite === 1'b1) && (writes_in_burst == BURST));
    if (usbEndBurst === 1'b1 || writes_in_burst >= BURST) begin
      check("ack_at_end", fifoAck, 0);
      writes_in_burst = 0;
    end
    if (expect_zero) begin
      check("rst_write", usbWrite, 0);
      check("rst_data", usbData, 0);
      check("rst_end", usbEndBurst, 0);
      check("rst_underrun", underrun, 0);
      check("rst_busy", busy, 0);
      expect_zero = 0;
    end
    if (reset) begin
      check("ack_in_reset", fifoAck, 0);
      exp_q.delete();
      tc_model = 0;
      writes_in_burst = 0;
      expect_zero = 1;
    end else begin
      check("ack_to_write", exp_q.size(), 0);
      if (fifoAck === 1'b1) begin
        exp_q.push_back(conv(testMode ? tc_model : int'(fifoData)));
        tc_model = (tc_model + 1) % 1024;
        total_acks++;
        pop_pending = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  task automatic wait_end(input int budget);
    int n = 0;
    bit done = 0;
    while (!done && n < budget) begin
      look();
      if (usbWrite && usbEndBurst) done = 1;
      n++;
    end
    if (!done) check("burst_timeout", 0, 1);
  endtask

  task automatic wait_words(input int target);
    int n = 0;
    while (writes_in_burst < target && n < 20000) begin
      look();
      n++;
    end
    if (writes_in_burst < target) check("word_timeout", writes_in_burst, target);
  endtask

  typedef struct {
    logic [9:0]  s;
    logic [15:0] w;
  } vec_t;

  vec_t vecs [6];
  int   acks0, writes0;
  bit   done;

  initial begin
    vecs[0] = '{10'h000, 16'hFE00};
    vecs[1] = '{10'h200, 16'h0000};
    vecs[2] = '{10'h3FF, 16'h01FF};
    vecs[3] = '{10'h1FF, 16'hFFFF};
    vecs[4] = '{10'h201, 16'h0001};
    vecs[5] = '{10'h0FF, 16'hFEFF};
    for (int i = 0; i < 65536; i++) mem[i] = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 6; i++) mem[i] = vecs[i].s;

    repeat (3) step();
    reset = 1'b0;
    look();
    check("idle_ack", fifoAck, 0);

    // Burst 1: start latency, conversion table, clean end.
    step();
    fifoHalfFull = 1'b1; usbReady = 1'b1; log_en = 1;
    look();
    check("start_busy_n", busy, 0);
    check("start_ack_n", fifoAck, 0);
    step();
    fifoHalfFull = 1'b0;
    look();
    check("start_ack_n1", fifoAck, 1);
    check("start_write_n1", usbWrite, 0);
    check("start_busy_n1", busy, 1);
    step();
    look();
    check("start_write_n2", usbWrite, 1);
    wait_end(20000);
    look();
    check("busy_after_end", busy, 0);
    check("burst1_words", wr_log.size(), BURST);
    for (int i = 0; i < 6; i++) check($sformatf("conv_%0d", i), wr_log[i], vecs[i].w);
    log_en = 0; wr_log.delete();

    // Burst 2: receiver stall with one-word skid.
    step();
    fifoHalfFull = 1'b1;
    step(); step();
    fifoHalfFull = 1'b0;
    wait_words(1000);
    step();
    usbReady = 1'b0;
    look();
    check("stall_ack0", fifoAck, 0);
    step(); look();
    check("stall_ack1", fifoAck, 0);
    check("stall_write1", usbWrite, 0);
    step(); look();
    check("stall_ack2", fifoAck, 0);
    check("stall_write2", usbWrite, 0);
    step();
    usbReady = 1'b1;
    wait_end(20000);
    check("stall_no_underrun", underrun, 0);

    // Burst 3: FIFO runs dry mid-burst.
    step();
    fifoHalfFull = 1'b1;
    step(); step();
    fifoHalfFull = 1'b0;
    wait_words(2000);
    check("pre_underrun", underrun, 0);
    step();
    fifoEmpty = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look();
      check("empty_ack", fifoAck, 0);
      step();
    end
    fifoEmpty = 1'b0;
    look();
    check("underrun_set", underrun, 1);
    wait_end(20000);
    look();
    check("underrun_sticky", underrun, 1);

    // Bursts 4-5: counter pattern across a back-to-back burst boundary.
    step();
    testMode = 1'b1; log_en = 1;
    acks0 = total_acks; writes0 = total_writes;
    fifoHalfFull = 1'b1;
    wait_end(20000);
    step();
    fifoHalfFull = 1'b0;
    look();
    check("restart_ack", fifoAck, 1);
    wait_end(20000);
    check("tm_words", wr_log.size(), 2 * BURST);
    check("tm_first", wr_log[0], 16'hFE00);
    check("tm_1023", wr_log[1023], 16'h01FF);
    check("tm_wrap", wr_log[1024], 16'hFE00);
    check("tm_burst2_first", wr_log[BURST], 16'hFE00);
    check("tm_ack_eq_write", total_acks - acks0, total_writes - writes0);
    log_en = 0; wr_log.delete();

    // Reset mid-burst, then a fresh burst from counter 0.
    step();
    testMode = 1'b0;
    fifoHalfFull = 1'b1;
    step(); step();
    fifoHalfFull = 1'b0;
    wait_words(100);
    step();
    reset = 1'b1;
    look();
    check("reset_ack", fifoAck, 0);
    step();
    reset = 1'b0;
    look();
    step();
    testMode = 1'b1; log_en = 1;
    fifoHalfFull = 1'b1;
    step(); step();
    fifoHalfFull = 1'b0;
    wait_end(20000);
    check("post_reset_words", wr_log.size(), BURST);
    check("post_reset_tc0", wr_log[0], 16'hFE00);
    check("post_reset_tc1", wr_log[1], 16'hFE01);
    log_en = 0; wr_log.delete();

    // Endpoint not ready holds IDLE, then a randomized burst.
    step();
    usbReady = 1'b0; testMode = 1'b0;
    fifoHalfFull = 1'b1;
    for (int i = 0; i < 5; i++) begin
      look();
      check("notready_ack", fifoAck, 0);
      check("notready_busy", busy, 0);
      step();
    end
    usbReady = 1'b1;
    look();
    check("ready_edge_busy", busy, 0);
    step();
    fifoHalfFull = 1'b0;
    look();
    check("ready_stream", busy, 1);
    done = 0;
    for (int n = 0; n < 40000 && !done; n++) begin
      step();
      usbReady  = ($urandom_range(0, 3) != 0);
      testMode  = 1'($urandom_range(0, 1));
      fifoEmpty = ($urandom_range(0, 7) == 0);
      look();
      if (usbWrite && usbEndBurst) done = 1;
    end
    if (!done) check("random_timeout", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_burst_reader.md
# usb_burst_reader

Downstream consumer of the dual-clock sample FIFO, running in the FIFO's read-clock domain. Waits until the FIFO reports half full and the USB endpoint is ready, then drains a fixed-length burst of 10-bit samples through the FIFO's read-ahead port. Each sample is converted to a 16-bit two's-complement word and presented to the USB bus interface. A test mode replaces sample data with a wrapping counter for link verification.

## Interface
- BURST_WORDS, 8192, words per burst; must equal the FIFO half-full threshold; counter width = clog2(BURST_WORDS)
- clock  in  1  FIFO read clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- fifoData  in  10  FIFO read-ahead data, valid whenever fifoEmpty=0
- fifoEmpty  in  1  FIFO empty flag
- fifoHalfFull  in  1  FIFO half-full flag
- fifoAck  out  1  FIFO read acknowledge; consumes current word
- usbReady  in  1  endpoint can accept data
- testMode  in  1  1 = counter pattern instead of sample data
- usbData  out  16  converted word
- usbWrite  out  1  usbData valid strobe
- usbEndBurst  out  1  high with last word of burst
- underrun  out  1  sticky: FIFO ran empty mid-burst
- busy  out  1  burst in progress

## Operation
- States: IDLE, STREAM.
- IDLE: fifoAck=0. If fifoHalfFull=1 and usbReady=1 -> STREAM; wordCount <= 0.
- STREAM: fifoAck = usbReady & ~fifoEmpty & ~reset (combinational). On each acked cycle: register converted word, usbWrite <= 1, wordCount++.
- usbReady=0 in STREAM: stall; no ack, usbWrite <= 0, state and count held.
- fifoEmpty=1 with usbReady=1 in STREAM: underrun <= 1 (sticky), no ack, usbWrite <= 0, remain in STREAM until data returns.
- Acked cycle with wordCount = BURST_WORDS-1: usbEndBurst <= 1 alongside usbWrite; state -> IDLE; wordCount <= 0.
- Conversion (offset binary -> signed): w = sign-extend({~s[9], s[8:0]}) to 16 bits. 0x200 -> 0x0000, 0x000 -> 0xFE00, 0x3FF -> 0x01FF, 0x1FF -> 0xFFFF.
- testMode=1: s = 10-bit testCount instead of fifoData; fifoAck still asserted as in data mode (FIFO drains identically, data discarded). testCount increments on every acked cycle in either mode, wraps 1023 -> 0, and is not cleared between bursts. testMode is sampled per word.
- busy = (state==STREAM) | usbWrite.
- Reset, from any state including mid-burst: state IDLE, wordCount 0, testCount 0, usbData 0x0000, usbWrite 0, usbEndBurst 0, underrun 0, fifoAck 0 in the same cycle. A partial burst is abandoned; no usbEndBurst is generated.

## Timing
- Start: condition true at edge N -> STREAM from N+1; first fifoAck possible in cycle N+1; first usbWrite in cycle N+2.
- Data latency: fifoAck in cycle k -> usbWrite/usbData in cycle k+1 (one register stage).
- Skid: the receiver must accept one usbWrite in the cycle after it deasserts usbReady.
- End: last ack in cycle M -> usbWrite=usbEndBurst=1 in cycle M+1; state is IDLE in M+1; earliest next STREAM is M+2. usbEndBurst is a single-cycle pulse.
- Uninterrupted burst: exactly BURST_WORDS consecutive usbWrite cycles.
- All outputs except fifoAck are registered.

## Test plan
- Reset, then halfFull=1, usbReady=1, FIFO holding 0x000,0x200,0x3FF,0x1FF at burst start -> first usbWrite 2 cycles after the start condition; words 0xFE00, 0x0000, 0x01FF, 0xFFFF; exactly 8192 writes; usbEndBurst only on the 8192nd write; busy falls the following cycle.
- Toggle usbReady low for 3 cycles mid-burst -> at most 1 write after the drop, then none; count preserved; total 8192 writes; no underrun.
- Force fifoEmpty=1 for 5 cycles mid-burst with usbReady=1 -> underrun=1 and stays 1 after the burst ends; burst still completes with 8192 words.
- testMode=1 over two bursts -> sample values 0,1,...,1023,0,... continue across the burst boundary with no reset (second burst starts at 8192 mod 1024 = 0 -> 0xFE00); fifoAck count equals write count.
- Assert reset at word 100 -> all outputs 0 in the following cycle, fifoAck 0 during reset, no usbEndBurst; the next burst starts with wordCount 0 and testCount 0.
- halfFull=1 with usbReady=0 held -> remain IDLE, no fifoAck; raise usbReady -> STREAM on the next edge.
